// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 RV32M multiply/divide unit sitting behind ID/EX.
// Holds the pipeline through stallreq while the engine runs and presents the
// result to EX/MEM for exactly one cycle on valid_o.
//
//   state | meaning
//   IDLE  | waiting for an M-extension op; captures operands on md_start
//   MUL   | one shift-add step per cycle over the magnitude of the operands
//   DIV   | one restoring-subtract step per cycle over the magnitudes
//   DONE  | result valid for one cycle; pipeline advances, then back to IDLE
module ex_muldiv #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              md_start,
  input  logic [2:0]        md_op,
  input  logic [WIDTH-1:0]  reg1_i,
  input  logic [WIDTH-1:0]  reg2_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  output logic              stallreq,
  output logic              valid_o,
  output logic [WIDTH-1:0]  wdata_o,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;  // shifted multiplicand
  logic [WIDTH-1:0]     opb_q, opb_d;      // multiplier (shifted right) or divisor
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;      // final result must be negated
  logic [ADDR_W-1:0]    wd_q, wd_d;
  logic                 wreg_q, wreg_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 sgn1, sgn2, sa, sb;
  logic [WIDTH-1:0]     abs1, abs2;
  logic                 div_zero, div_ovf;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       rem_sh, diff;
  logic                 no_borrow;
  logic [2*WIDTH-1:0]   div_step;

  // Sign fix-up and result select from the finished accumulator.
  function automatic logic [WIDTH-1:0] fixup(input logic [2*WIDTH-1:0] acc,
                                             input logic [2:0] op,
                                             input logic neg);
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   r;
    if (!op[2]) begin
      p = neg ? ('0 - acc) : acc;
      r = (op[1:0] == 2'd0) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
    end else begin
      r = op[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
      r = neg ? ('0 - r) : r;
    end
    return r;
  endfunction

  // Operand decode for a new request: signedness, magnitudes, divide corner cases.
  always_comb begin
    sgn1     = (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd4) || (md_op == 3'd6);
    sgn2     = (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
    sa       = sgn1 & reg1_i[WIDTH-1];
    sb       = sgn2 & reg2_i[WIDTH-1];
    abs1     = sa ? ('0 - reg1_i) : reg1_i;
    abs2     = sb ? ('0 - reg2_i) : reg2_i;
    div_zero = md_op[2] && (reg2_i == '0);
    div_ovf  = md_op[2] && !md_op[0] && (reg1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (reg2_i == '1);
  end

  // One engine step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_step  = opb_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, opb_q};
    no_borrow = ~diff[WIDTH];
    div_step  = {(no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], no_borrow};
  end

  // Next-state, datapath update and stall request.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    result_d = result_q;
    stallreq = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_start && !flush) begin
          stallreq = 1'b1;
          op_d     = md_op;
          wd_d     = wd_i;
          wreg_d   = wreg_i;
          neg_d    = (md_op[2] && md_op[1]) ? sa : (sa ^ sb);
          count_d  = '0;
          if (div_zero) begin
            result_d = md_op[1] ? reg1_i : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = md_op[1] ? '0 : reg1_i;
            state_d  = S_DONE;
          end else if (md_op[2]) begin
            acc_d   = {{WIDTH{1'b0}}, abs1};
            opb_d   = abs2;
            state_d = S_DIV;
          end else begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, abs1};
            opb_d   = abs2;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        stallreq = 1'b1;
        acc_d    = mul_step;
        mcand_d  = mcand_q << 1;
        opb_d    = opb_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          result_d = fixup(mul_step, op_q, neg_q);
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        stallreq = 1'b1;
        acc_d    = div_step;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          result_d = fixup(div_step, op_q, neg_q);
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      result_q <= result_d;
    end
  end

  // A flush arriving in DONE discards the result as well.
  assign valid_o = (state_q == S_DONE) && !flush;
  assign wdata_o = result_q;
  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q & valid_o;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed corner cases, aborts, back-to-back
// issue and randomized ops checked against a plain-arithmetic reference model.
module tb_ex_muldiv;
  localparam int W = 32;
  localparam int A = 5;

  logic          clk = 1'b0;
  logic          rst, flush, md_start;
  logic [2:0]    md_op;
  logic [W-1:0]  reg1_i, reg2_i;
  logic [A-1:0]  wd_i;
  logic          wreg_i;
  logic          stallreq, valid_o;
  logic [W-1:0]  wdata_o;
  logic [A-1:0]  wd_o;
  logic          wreg_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [A-1:0] wd;
    logic         wreg;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  ex_muldiv #(.WIDTH(W), .ADDR_W(A)) dut (
    .clk(clk), .rst(rst), .flush(flush), .md_start(md_start), .md_op(md_op),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .stallreq(stallreq), .valid_o(valid_o), .wdata_o(wdata_o),
    .wd_o(wd_o), .wreg_o(wreg_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RV32M semantics using native wide arithmetic.
  function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [63:0] x, y, p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin x = {32'b0, a}; y = {32'b0, b}; p = x * y; return p[31:0]; end
      3'd1: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
      3'd2: begin x = {{32{a[31]}}, a}; y = {32'b0, b}; p = x * y; return p[63:32]; end
      3'd3: begin x = {32'b0, a}; y = {32'b0, b}; p = x * y; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Monitor: pops one expected result per valid_o and compares it.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid_o=1 with wdata 0x%08h expected no result at %0t",
                   wdata_o, $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("wdata", wdata_o, mon_e.data);
          check("wd", {27'b0, wd_o}, {27'b0, mon_e.wd});
          check("wreg", {31'b0, wreg_o}, {31'b0, mon_e.wreg});
        end
      end else begin
        check("wreg_qualified", {31'b0, wreg_o}, 32'd0);
      end
    end
  end

  // Issue one op, measure stall/valid timing; hold keeps md_start high through DONE.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [A-1:0] wdv, input logic wrv, input bit hold);
    exp_t e;
    int   vcyc, stall_cnt, lat;
    @(posedge clk); #1;
    md_start = 1'b1; md_op = op; reg1_i = a; reg2_i = b; wd_i = wdv; wreg_i = wrv;
    e.data = ref_model(op, a, b); e.wd = wdv; e.wreg = wrv;
    sb_q.push_back(e);
    lat = is_special(op, a, b) ? 1 : W + 1;
    vcyc = -1;
    stall_cnt = 0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (valid_o) begin
        vcyc = c;
        break;
      end
      if (stallreq) stall_cnt++;
      @(posedge clk); #1;
    end
    check("valid_latency", 32'(vcyc), 32'(lat));
    check("stall_cycles", 32'(stall_cnt), 32'(lat));
    check("stall_at_done", {31'b0, stallreq}, 32'd0);
    if (!hold) begin
      @(posedge clk); #1;
      md_start = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Start a DIV, abort it in cycle 10 with flush or rst, confirm nothing comes out.
  task automatic abort_test(input bit use_rst);
    @(posedge clk); #1;
    md_start = 1'b1; md_op = 3'd4; reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd17; wreg_i = 1'b1;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; md_start = 1'b0;
    @(negedge clk);
    check(use_rst ? "rst_stallreq" : "flush_stallreq", {31'b0, stallreq}, 32'd0);
    check(use_rst ? "rst_valid" : "flush_valid", {31'b0, valid_o}, 32'd0);
    if (use_rst) begin
      check("rst_wdata", wdata_o, 32'd0);
      check("rst_wd", {27'b0, wd_o}, 32'd0);
      check("rst_wreg", {31'b0, wreg_o}, 32'd0);
    end
    idle_cycles(40);
  endtask

  logic [W-1:0] edge_v [5];

  initial begin
    edge_v[0] = 32'h0; edge_v[1] = 32'h1; edge_v[2] = 32'hFFFF_FFFF;
    edge_v[3] = 32'h8000_0000; edge_v[4] = 32'h7FFF_FFFF;
    rst = 1'b1; flush = 1'b0; md_start = 1'b0; md_op = '0;
    reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stallreq", {31'b0, stallreq}, 32'd0);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_wdata", wdata_o, 32'd0);
    check("reset_wd", {27'b0, wd_o}, 32'd0);
    check("reset_wreg", {31'b0, wreg_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b1, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd10, 1'b1, 0);
    run_op(3'd5, 32'd5, 32'd0, 5'd11, 1'b1, 0);
    run_op(3'd6, 32'd5, 32'd0, 5'd12, 1'b1, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 0);

    // flush alongside a new request in IDLE: nothing captured
    @(posedge clk); #1;
    md_start = 1'b1; flush = 1'b1; md_op = 3'd0; reg1_i = 32'd3; reg2_i = 32'd4;
    @(negedge clk);
    check("flush_idle_stallreq", {31'b0, stallreq}, 32'd0);
    @(posedge clk); #1;
    md_start = 1'b0; flush = 1'b0;
    idle_cycles(40);

    abort_test(0);
    abort_test(1);

    // back-to-back with md_start held high across DONE
    run_op(3'd0, 32'd12345, 32'd678, 5'd20, 1'b1, 1);
    run_op(3'd4, 32'hFFFF_FC18, 32'd7, 5'd21, 1'b1, 0);

    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 5))
        0: b = edge_v[$urandom_range(0, 4)];
        1: b = 32'd0;
        2: b = $urandom_range(1, 300);
        default: b = $urandom;
      endcase
      run_op(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             0);
    end

    idle_cycles(5);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected completion");
    $fatal(1, "watchdog");
  end

endmodule
